// File: rtl/sf_ascii_sched_pkg.sv
// sf_ascii_sched_pkg: shared state encoding and defaults for the ASCII line scheduler
package sf_ascii_sched_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_DONE} t_sched_state;
   localparam int unsigned c_default_period = 40_000_000;
   localparam int unsigned c_default_chars  = 35;
endpackage

// File: rtl/sf_ascii_period_timer.sv
// sf_ascii_period_timer: free-running 0..parm_period_cycles-1 counter, o_tick on the wrap cycle
module sf_ascii_period_timer import sf_ascii_sched_pkg::*; #(
   parameter int unsigned parm_period_cycles = c_default_period
)(
   input  logic i_clk_40mhz,
   input  logic i_rst_40mhz_n,
   output logic o_tick
);
   logic [31:0] cnt;
   assign o_tick = (cnt == parm_period_cycles - 1);
   // count up, wrapping to zero on the tick cycle
   always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz_n)
      if (!i_rst_40mhz_n) cnt <= '0;
      else cnt <= o_tick ? '0 : cnt + 32'd1;
endmodule

// File: rtl/sf_ascii_line_scheduler.sv
// sf_ascii_line_scheduler: snapshots terminal/LCD text periodically or on demand and streams the
// terminal line to the UART one char at a time. Optional SF_SCHED_SKIP_DUPLICATE_EN suppresses
// periodic lines whose text matches the last line sent.
module sf_ascii_line_scheduler import sf_ascii_sched_pkg::*; #(
   parameter int unsigned parm_period_cycles = c_default_period,
   parameter int unsigned parm_line_chars    = c_default_chars
)(
   input  logic                         i_clk_40mhz,
   input  logic                         i_rst_40mhz_n,
   input  logic [8*parm_line_chars-1:0] i_term_ascii_line,
   input  logic [127:0]                 i_lcd_ascii_line1,
   input  logic [127:0]                 i_lcd_ascii_line2,
   input  logic                         i_force_send,
   output logic [7:0]                   o_tx_data,
   output logic                         o_tx_valid,
   input  logic                         i_tx_ready,
   output logic [127:0]                 o_lcd_ascii_line1,
   output logic [127:0]                 o_lcd_ascii_line2,
   output logic                         o_lcd_update,
   output logic                         o_line_done,
   output logic                         o_busy
);
   localparam int unsigned     c_iw   = $clog2(parm_line_chars);
   localparam logic [c_iw-1:0] c_last = c_iw'(parm_line_chars - 1);

   t_sched_state                 state, state_n;
   logic                         tick, trig, hs, pending, skip;
   logic [c_iw-1:0]              idx;
   logic [8*parm_line_chars-1:0] snap;

   sf_ascii_period_timer #(.parm_period_cycles(parm_period_cycles)) u_timer (
      .i_clk_40mhz   (i_clk_40mhz),
      .i_rst_40mhz_n (i_rst_40mhz_n),
      .o_tick        (tick)
   );

   assign trig = tick | i_force_send;
   assign hs   = o_tx_valid & i_tx_ready;

`ifdef SF_SCHED_SKIP_DUPLICATE_EN
   logic                         frc;
   logic [8*parm_line_chars-1:0] last_sent;
   // a line is only skipped when no force has been seen since the previous load
   assign skip = (i_term_ascii_line == last_sent) && !frc;
   // remember forced requests until they are loaded, and the last fully sent line
   always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz_n)
      if (!i_rst_40mhz_n) begin
         frc       <= 1'b0;
         last_sent <= '0;
      end else begin
         frc       <= (state == ST_LOAD) ? i_force_send : (frc | i_force_send);
         last_sent <= (state == ST_DONE) ? snap : last_sent;
      end
`else
   assign skip = 1'b0;
`endif

   // state register
   always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz_n)
      if (!i_rst_40mhz_n) state <= ST_IDLE;
      else state <= state_n;

   // next state; a pending request left over from a skipped load is honoured from idle too
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: state_n = (trig | pending) ? ST_LOAD : ST_IDLE;
         ST_LOAD: state_n = skip ? ST_IDLE : ST_SEND;
         ST_SEND: state_n = (hs && idx == c_last) ? ST_DONE : ST_SEND;
         ST_DONE: state_n = (trig | pending) ? ST_LOAD : ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // outputs decoded from state; data comes straight from the frozen snapshot
   always_comb begin
      o_busy       = (state == ST_LOAD) || (state == ST_SEND);
      o_tx_valid   = (state == ST_SEND);
      o_lcd_update = (state == ST_LOAD) && !skip;
      o_line_done  = (state == ST_DONE);
      o_tx_data    = snap[8*(parm_line_chars - 1 - 32'(idx)) +: 8];
   end

   // snapshot capture, char index and one-deep merged request flag
   always_ff @(posedge i_clk_40mhz or negedge i_rst_40mhz_n)
      if (!i_rst_40mhz_n) begin
         pending           <= 1'b0;
         idx               <= '0;
         snap              <= '0;
         o_lcd_ascii_line1 <= '0;
         o_lcd_ascii_line2 <= '0;
      end else begin
         pending <= ((state != ST_IDLE) && trig) | (pending && (state != ST_LOAD));
         if (state == ST_LOAD) begin
            idx  <= '0;
            snap <= i_term_ascii_line;
            if (!skip) begin
               o_lcd_ascii_line1 <= i_lcd_ascii_line1;
               o_lcd_ascii_line2 <= i_lcd_ascii_line2;
            end
         end else if (hs && idx != c_last) idx <= idx + 1'b1;
      end
endmodule
